// File: rtl/scan_select_if.sv
// scan_select_if: control inputs and decoder-facing outputs of the scan select sequencer
interface scan_select_if;
    logic       en;
    logic       start;
    logic       stop;
    logic [7:0] mask;
    logic [2:0] chan_idx;
    logic [2:0] sel_code;
    logic       sel_valid;
    logic       wrap;
    logic       busy;
    modport master (
        output en, start, stop, mask,
        input  chan_idx, sel_code, sel_valid, wrap, busy
    );
    modport slave (
        input  en, start, stop, mask,
        output chan_idx, sel_code, sel_valid, wrap, busy
    );
endinterface

// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer: round-robin channel stepper with dwell timer feeding a 3-to-8 decoder
module scan_select_sequencer #(
    parameter int DWELL   = 4,
    parameter int DWELL_W = $clog2(DWELL) + 1
) (
    input logic          clk,
    input logic          rst,
    scan_select_if.slave bus
);
    typedef enum logic {IDLE, DWELL_ST} state_t;
    localparam logic [DWELL_W-1:0] DW_LAST = DWELL_W'(DWELL - 1);
    state_t               state_q, state_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           chan_q, chan_d, next_chan, first_chan;
    logic                 wrap_q, wrap_d;
    logic                 pend_q, pend_d;
    // Lowest-offset set bit wins because it is assigned last.
    function automatic logic [2:0] first_set(input logic [7:0] m, input logic [2:0] from);
        first_set = from;
        for (int i = 7; i >= 0; i--)
            if (m[from + 3'(i)]) first_set = from + 3'(i);
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
            wrap_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            wrap_q  <= wrap_d;
            pend_q  <= pend_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chan_d     = chan_q;
        wrap_d     = 1'b0;
        pend_d     = pend_q;
        next_chan  = first_set(bus.mask, chan_q + 3'd1);
        first_chan = first_set(bus.mask, 3'd0);
        if (state_q == IDLE) begin
            pend_d = 1'b0;
            if (bus.start && |bus.mask) begin
                state_d = DWELL_ST;
                chan_d  = first_chan;
                cnt_d   = DW_LAST;
            end
        end else if (!bus.en || cnt_q != '0) begin
            // A stop here only arms; the current channel still finishes its dwell.
            pend_d = pend_q | bus.stop;
            cnt_d  = bus.en ? cnt_q - DWELL_W'(1) : cnt_q;
        end else if (pend_q || bus.stop || bus.mask == 8'h00) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end else begin
            chan_d = next_chan;
            cnt_d  = DW_LAST;
            wrap_d = next_chan <= chan_q;
        end
    end
    assign bus.chan_idx  = chan_q;
    assign bus.sel_code  = {chan_q[0], chan_q[1], chan_q[2]};
    assign bus.sel_valid = state_q == DWELL_ST;
    assign bus.busy      = state_q == DWELL_ST;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_scan_select_sequencer.sv
// tb_scan_select_sequencer: directed checks of scan order, dwell, stall, stop and reset
module tb_scan_select_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    scan_select_if bus();
    scan_select_sequencer #(.DWELL(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_idx"},   32'(bus.chan_idx), 0);
        chk({tag, "_code"},  32'(bus.sel_code), 0);
        chk({tag, "_valid"}, 32'(bus.sel_valid), 0);
        chk({tag, "_wrap"},  32'(bus.wrap), 0);
        chk({tag, "_busy"},  32'(bus.busy), 0);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.mask = 8'h00;
        tick();
        rst = 1'b0;
    endtask
    task automatic launch(input logic [7:0] m);
        bus.mask = m; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    logic [2:0] seq3 [5] = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};
    logic [2:0] exp_chan;
    initial begin
        // 1: reset with random inputs
        bus.en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.mask = 8'h00;
        for (int i = 0; i < 2; i++) begin
            bus.en = 1'($urandom); bus.start = 1'($urandom);
            bus.stop = 1'($urandom); bus.mask = 8'($urandom);
            tick();
            chk_idle("rst");
        end
        rst = 1'b0; bus.en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        tick();
        chk_idle("post_rst");
        // 2: full mask, full pass then wrap
        do_reset();
        launch(8'hFF);
        for (int k = 1; k <= 32; k++) begin
            chk("full_idx",   32'(bus.chan_idx), 32'((k - 1) / 4));
            chk("full_valid", 32'(bus.sel_valid), 1);
            chk("full_wrap",  32'(bus.wrap), 0);
            if (k == 5)  chk("code_ch1", 32'(bus.sel_code), 32'(3'b100));
            if (k == 17) chk("code_ch4", 32'(bus.sel_code), 32'(3'b001));
            if (k == 25) chk("code_ch6", 32'(bus.sel_code), 32'(3'b011));
            tick();
        end
        chk("full_c33_idx",  32'(bus.chan_idx), 0);
        chk("full_c33_wrap", 32'(bus.wrap), 1);
        tick();
        chk("full_c34_wrap", 32'(bus.wrap), 0);
        // 3: sparse mask 2,5,7
        do_reset();
        launch(8'b1010_0100);
        for (int k = 1; k <= 20; k++) begin
            chk("sparse_idx",  32'(bus.chan_idx), 32'(seq3[(k - 1) / 4]));
            chk("sparse_wrap", 32'(bus.wrap), 32'(k == 13));
            tick();
        end
        // 3b: single channel wraps each dwell
        do_reset();
        launch(8'h08);
        for (int k = 1; k <= 12; k++) begin
            chk("single_idx",  32'(bus.chan_idx), 3);
            chk("single_wrap", 32'(bus.wrap), 32'(k == 5 || k == 9));
            tick();
        end
        // 4: en low for 3 cycles during chan 1
        do_reset();
        launch(8'hFF);
        for (int k = 1; k <= 12; k++) begin
            exp_chan = k <= 4 ? 3'd0 : k <= 11 ? 3'd1 : 3'd2;
            chk("stall_idx",  32'(bus.chan_idx), 32'(exp_chan));
            chk("stall_wrap", 32'(bus.wrap), 0);
            if (exp_chan == 3'd1) chk("stall_code", 32'(bus.sel_code), 32'(3'b100));
            bus.en = !(k >= 6 && k <= 8);
            tick();
        end
        bus.en = 1'b1;
        // 5: stop during chan 3 completes the dwell
        do_reset();
        launch(8'hFF);
        for (int k = 1; k <= 16; k++) begin
            chk("stop_idx",  32'(bus.chan_idx), 32'((k - 1) / 4));
            chk("stop_busy", 32'(bus.busy), 1);
            bus.stop = k == 14;
            tick();
        end
        bus.stop = 1'b0;
        chk("stop_valid", 32'(bus.sel_valid), 0);
        chk("stop_busy0", 32'(bus.busy), 0);
        chk("stop_keep",  32'(bus.chan_idx), 3);
        chk("stop_code",  32'(bus.sel_code), 32'(3'b110));
        tick();
        chk("stop_still", 32'(bus.busy), 0);
        launch(8'h00);
        chk("start_nomask", 32'(bus.busy), 0);
        bus.stop = 1'b1;
        launch(8'h30);
        bus.stop = 1'b0;
        chk("startstop_busy", 32'(bus.sel_valid), 1);
        chk("startstop_idx",  32'(bus.chan_idx), 4);
        for (int k = 0; k < 4; k++) tick();
        chk("startstop_run",  32'(bus.busy), 1);
        chk("startstop_next", 32'(bus.chan_idx), 5);
        // 6: mask cleared mid-dwell ends the scan at dwell end
        do_reset();
        launch(8'hFF);
        tick();
        bus.mask = 8'h00;
        tick();
        chk("mask0_c3", 32'(bus.busy), 1);
        tick();
        chk("mask0_c4", 32'(bus.busy), 1);
        tick();
        chk("mask0_idle", 32'(bus.busy), 0);
        chk("mask0_idx",  32'(bus.chan_idx), 0);
        // 6b: reset mid-dwell of chan 5
        do_reset();
        launch(8'hFF);
        for (int k = 1; k < 22; k++) tick();
        chk("pre_rst_idx", 32'(bus.chan_idx), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("mid_rst");
        tick();
        chk_idle("mid_rst_after");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
